// File: rtl/line_fill_responder_pkg.sv
// Shared constants for the I-cache line-fill responder: default geometry,
// derived word/offset widths and the FSM state encoding.
package line_fill_responder_pkg;

  // Default geometry: word width, line width and what falls out of them
  localparam int DW        = 32;
  localparam int LINE_BITS = 256;
  localparam int WORDS     = LINE_BITS / DW;
  localparam int OFS       = $clog2(LINE_BITS / 8);
  localparam int CNT_W     = (WORDS > 1) ? $clog2(WORDS) : 1;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/line_fill_responder.sv
// Memory-side responder for the L1 I-cache line-fill port. One line request
// is turned into WORDS sequential word reads; the words are packed into the
// line register (word 0 in the top slice) and a one-cycle ready pulse is
// issued. A HOLD cycle after DONE swallows the requester's still-high strobe.
module line_fill_responder
  import line_fill_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = DW,
  parameter int LINE_SIZE  = LINE_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  c_strobe_i,
  input  logic [ADDR_WIDTH-1:0] c_addr_i,
  output logic                  c_ready_o,
  output logic [LINE_SIZE-1:0]  c_data_o,
  output logic                  w_req_o,
  output logic [ADDR_WIDTH-1:0] w_addr_o,
  input  logic                  w_ack_i,
  input  logic [DATA_WIDTH-1:0] w_data_i
);

  localparam int N_WORDS  = LINE_SIZE / DATA_WIDTH;
  localparam int OFS_BITS = $clog2(LINE_SIZE / 8);
  localparam int CW       = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int STEP     = DATA_WIDTH / 8;

  localparam logic [CW-1:0]         LAST_WORD = CW'(N_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(STEP);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          fill_word;

  // Byte offset within the line is irrelevant: fills always start at word 0
  logic addr_ofs_unused;
  assign addr_ofs_unused = ^c_addr_i[OFS_BITS-1:0];

  // A word lands in the line buffer only while fetching and acknowledged
  assign fill_word = (state == ST_FETCH) && w_ack_i;

  // Control FSM: request acceptance, word address walk, ready pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      w_req_o   <= 1'b0;
      w_addr_o  <= '0;
      c_ready_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          c_ready_o <= 1'b0;
          if (c_strobe_i) begin
            w_addr_o <= {c_addr_i[ADDR_WIDTH-1:OFS_BITS], {OFS_BITS{1'b0}}};
            w_req_o  <= 1'b1;
            cnt      <= '0;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (w_ack_i) begin
            if (cnt == LAST_WORD) begin
              w_req_o   <= 1'b0;
              c_ready_o <= 1'b1;
              state     <= ST_DONE;
            end else begin
              cnt      <= cnt + 1'b1;
              w_addr_o <= w_addr_o + ADDR_STEP;
            end
          end
        end
        ST_DONE: begin
          c_ready_o <= 1'b0;
          state     <= ST_HOLD;
        end
        default: begin
          // HOLD: strobe deliberately not looked at this cycle
          c_ready_o <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Line buffer: write the acknowledged word into its slice, word 0 at the top
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      c_data_o <= '0;
    end else if (fill_word) begin
      c_data_o[LINE_SIZE-1-int'(cnt)*DATA_WIDTH -: DATA_WIDTH] <= w_data_i;
    end
  end

endmodule

// File: tb/tb_line_fill_responder.sv
// Bench for line_fill_responder: a word-memory model answers word requests
// with a programmable number of wait cycles, requests push the expected line
// and ready cycle into a queue, and a monitor pops on every ready pulse.
module tb_line_fill_responder;

  typedef struct {
    logic [255:0] line;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         c_strobe;
  logic [31:0]  c_addr;
  logic         c_ready;
  logic [255:0] c_data;
  logic         w_req;
  logic [31:0]  w_addr;
  logic         w_ack;
  logic [31:0]  w_data;

  int   tot_cnt   = 0;
  int   pass_cnt  = 0;
  int   cyc       = 0;
  int   mem_waits = 0;
  int   ready_cnt = 0;
  bit   manual    = 1'b0;
  bit   fill_open = 1'b0;
  logic [31:0] exp_addr = 32'h0;
  exp_t q[$];

  localparam logic [255:0] T1_LINE =
    256'h00000011_00000022_00000033_00000044_00000055_00000066_00000077_00000088;

  line_fill_responder dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .c_strobe_i (c_strobe),
    .c_addr_i   (c_addr),
    .c_ready_o  (c_ready),
    .c_data_o   (c_data),
    .w_req_o    (w_req),
    .w_addr_o   (w_addr),
    .w_ack_i    (w_ack),
    .w_data_i   (w_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Memory content: low byte (index+1)*0x11, top byte from address bits 15:8
  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [7:0] idx;
    logic [7:0] lo;
    idx = {5'd0, a[4:2]};
    lo  = (idx + 8'd1) * 8'd17;
    return {a[15:8], 16'h0000, lo};
  endfunction

  function automatic logic [255:0] model_line(input logic [31:0] base);
    logic [255:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l[255-32*i -: 32] = word_of(base + 32'(4*i));
    return l;
  endfunction

  // Word memory: answers w_req after mem_waits idle cycles, checks the address walk
  initial begin
    int wc;
    wc = 0;
    w_ack = 1'b0;
    w_data = 32'h0;
    forever begin
      @(negedge clk);
      if (!manual) begin
        if (!rst && !fill_open) chk("w_req_idle", 256'(w_req), 256'(0));
        if (!rst && w_req) begin
          chk("w_addr", 256'(w_addr), 256'(exp_addr));
          if (wc >= mem_waits) begin
            w_ack = 1'b1;
            w_data = word_of(w_addr);
            exp_addr = exp_addr + 32'd4;
            wc = 0;
          end else begin
            w_ack = 1'b0;
            wc++;
          end
        end else begin
          w_ack = 1'b0;
          wc = 0;
        end
      end
    end
  end

  // Monitor: every ready pulse must match the oldest outstanding request
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && c_ready === 1'b1) begin
        ready_cnt++;
        fill_open = 1'b0;
        chk("pending_request", 256'(q.size() != 0), 256'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("line_data", c_data, e.line);
          chk("ready_cycle", 256'(cyc), 256'(e.cyc));
        end
      end
    end
  end

  // Issue one line request; returns on the negedge where ready is seen
  // (or, with hold_strobe, after keeping strobe high through DONE and HOLD)
  task automatic request(input logic [31:0] addr, input int waits, input bit hold_strobe);
    exp_t e;
    int n;
    @(negedge clk);
    mem_waits = waits;
    c_strobe = 1'b1;
    c_addr = addr;
    exp_addr = addr & ~32'h1F;
    fill_open = 1'b1;
    e.line = model_line(addr & ~32'h1F);
    e.cyc = cyc + 8 * (waits + 1) + 1;
    q.push_back(e);
    n = 0;
    if (!hold_strobe) begin
      @(negedge clk);
      c_strobe = 1'b0;
    end
    while (c_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("ready_seen", 256'(c_ready), 256'(1));
    if (hold_strobe) begin
      @(negedge clk);
      @(negedge clk);
      c_strobe = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    c_strobe = 1'b0;
    c_addr = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_w_req", 256'(w_req), 256'(0));
    chk("rst_w_addr", 256'(w_addr), 256'(0));
    chk("rst_c_ready", 256'(c_ready), 256'(0));
    chk("rst_c_data", c_data, 256'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // T1: zero-wait fill, offset address inside the line
    request(32'h8000_0014, 0, 1'b0);
    chk("t1_line", c_data, T1_LINE);
    @(negedge clk);
    chk("t1_ready_one_cycle", 256'(c_ready), 256'(0));
    @(negedge clk);

    // T2: two wait cycles per word
    request(32'h8000_0024, 2, 1'b0);
    repeat (3) @(negedge clk);

    // T3: strobe held through DONE and HOLD must not start a second fill
    request(32'h8000_0060, 0, 1'b1);
    repeat (15) @(negedge clk);
    chk("t3_ready_count", 256'(ready_cnt), 256'(3));

    // T4: second request in the first IDLE cycle after HOLD
    request(32'h8000_0040, 0, 1'b0);
    @(negedge clk);
    request(32'h8000_0100, 0, 1'b0);
    chk("t4_line2", c_data, model_line(32'h8000_0100));
    @(negedge clk);
    chk("t4_ready_count", 256'(ready_cnt), 256'(5));

    // T5: reset after the third ack, stray ack afterwards
    repeat (2) @(negedge clk);
    manual = 1'b1;
    w_ack = 1'b0;
    c_strobe = 1'b1;
    c_addr = 32'h8000_0208;
    @(negedge clk);
    c_strobe = 1'b0;
    chk("t5_w_req_up", 256'(w_req), 256'(1));
    w_ack = 1'b1;
    w_data = 32'h0000_00A1;
    @(negedge clk);
    w_data = 32'h0000_00A2;
    @(negedge clk);
    w_data = 32'h0000_00A3;
    @(negedge clk);
    rst = 1'b1;
    w_data = 32'hDEAD_BEEF;
    #1;
    chk("t5_rst_w_req", 256'(w_req), 256'(0));
    chk("t5_rst_w_addr", 256'(w_addr), 256'(0));
    chk("t5_rst_c_ready", 256'(c_ready), 256'(0));
    chk("t5_rst_c_data", c_data, 256'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    w_ack = 1'b0;
    chk("t5_post_w_req", 256'(w_req), 256'(0));
    chk("t5_post_c_data", c_data, 256'(0));
    chk("t5_post_ready_count", 256'(ready_cnt), 256'(5));
    manual = 1'b0;
    @(negedge clk);
    request(32'h8000_0208, 0, 1'b0);
    repeat (3) @(negedge clk);

    // T6: acks while idle are ignored
    manual = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      w_ack = ~i[0];
      w_data = 32'hFFFF_0000 + 32'(i);
      chk("t6_w_req", 256'(w_req), 256'(0));
      chk("t6_c_ready", 256'(c_ready), 256'(0));
    end
    @(negedge clk);
    w_ack = 1'b0;
    @(negedge clk);
    chk("t6_c_data_kept", c_data, model_line(32'h8000_0200));
    chk("t6_w_req_final", 256'(w_req), 256'(0));
    manual = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_ready_count", 256'(ready_cnt), 256'(6));
    chk("final_queue_empty", 256'(q.size()), 256'(0));

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
